// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master and apb_slave_mem.
// PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;
`endif
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 word-addressed memory slave with wait states and range error.
// Define APB_SLV_PSTRB_EN to enable byte-lane write strobes.
module apb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic            pclk,
    input logic            presetn,
    apb_slave_mem_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);
    localparam logic [3:0]    WS_W    = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  err;
    logic                  wr;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NB-1:0]         strb;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         bus_idx;
    logic                  bus_err;
    logic [NB-1:0]         bus_strb;

    assign bus_idx = bus.paddr[IW-1:0];
    assign bus_err = {1'b0, bus.paddr} >= DEPTH_W;

`ifdef APB_SLV_PSTRB_EN
    assign bus_strb = bus.pstrb;
`else
    assign bus_strb = '1;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
            wr    <= 1'b0;
            idx   <= '0;
            wdata <= '0;
            rdata <= '0;
            strb  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // PENABLE high here is a protocol violation; ignore it
                    if (bus.psel && !bus.penable) begin
                        state <= ACCESS;
                        cnt   <= WS_W;
                        err   <= bus_err;
                        wr    <= bus.pwrite;
                        idx   <= bus_idx;
                        wdata <= bus.pwdata;
                        strb  <= bus_strb;
                        if (!bus.pwrite)
                            rdata <= bus_err ? '0 : mem[bus_idx];
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (bus.penable) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                            if (wr && !err) begin
                                for (int i = 0; i < NB; i++)
                                    if (strb[i])
                                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response decoded purely from registered state, never from bus inputs
    assign bus.prdata  = rdata;
    assign bus.pready  = (state == ACCESS) && (cnt == 4'd0);
    assign bus.pslverr = bus.pready && err;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: two instances, zero-wait/DEPTH=200
// and three-wait, sharing one set of bus drivers gated by dsel.
module tb_apb_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dsel, psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    logic        rdy, slv;
    logic [31:0] rd;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    apb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) b0 ();
    apb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) b1 ();

    assign b0.psel    = psel & ~dsel;
    assign b0.penable = penable;
    assign b0.pwrite  = pwrite;
    assign b0.paddr   = paddr;
    assign b0.pwdata  = pwdata;
    assign b1.psel    = psel & dsel;
    assign b1.penable = penable;
    assign b1.pwrite  = pwrite;
    assign b1.paddr   = paddr;
    assign b1.pwdata  = pwdata;
`ifdef APB_SLV_PSTRB_EN
    assign b0.pstrb   = pstrb;
    assign b1.pstrb   = pstrb;
`endif

    assign rdy = dsel ? b1.pready  : b0.pready;
    assign slv = dsel ? b1.pslverr : b0.pslverr;
    assign rd  = dsel ? b1.prdata  : b0.prdata;

    apb_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)
    ) u0 (.pclk(clk), .presetn(rst_n), .bus(b0));

    apb_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(3)
    ) u1 (.pclk(clk), .presetn(rst_n), .bus(b1));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit d, input bit w, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rv,
                        output logic e, output int cyc, output int low);
        dsel = d; psel = 1'b1; penable = 1'b0;
        pwrite = w; paddr = a; pwdata = wd;
        cyc = 1; low = 0;
        @(posedge clk); #1;
        penable = 1'b1; cyc++;
        while (!rdy && cyc < 60) begin
            low++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!rdy) check("timeout", {63'b0, rdy}, 64'd1);
        rv = rd; e = slv;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          c, l;
        time         t0;
        dsel = 0; psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0;
`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_prdata", {32'b0, b0.prdata}, 64'h0);
        check("rst_pready", {63'b0, b0.pready}, 64'h0);
        check("rst_pslverr", {63'b0, b0.pslverr}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // load a value, then reset in the middle of a write
        xfer(0, 1, 8'h05, 32'h11111111, r, e, c, l);
        xfer(0, 0, 8'h05, 32'h0, r, e, c, l);
        check("pre_rst_rd", {32'b0, r}, 64'h11111111);
        dsel = 0; psel = 1; penable = 0; pwrite = 1;
        paddr = 8'h05; pwdata = 32'h22222222;
        @(posedge clk); #1;
        penable = 1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_prdata", {32'b0, b0.prdata}, 64'h0);
        check("mid_rst_pready", {63'b0, b0.pready}, 64'h0);
        check("mid_rst_pslverr", {63'b0, b0.pslverr}, 64'h0);
        psel = 0; penable = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 0, 8'h05, 32'h0, r, e, c, l);
        check("rst_mem_rd", {32'b0, r}, 64'h0);

        xfer(0, 1, 8'h10, 32'hDEADBEEF, r, e, c, l);
        check("zw_wr_cyc", 64'(c), 64'd2);
        check("zw_wr_err", {63'b0, e}, 64'h0);
        xfer(0, 0, 8'h10, 32'h0, r, e, c, l);
        check("zw_rd_data", {32'b0, r}, 64'hDEADBEEF);
        check("zw_rd_cyc", 64'(c), 64'd2);
        check("zw_rd_err", {63'b0, e}, 64'h0);

        xfer(1, 1, 8'h10, 32'hCAFEF00D, r, e, c, l);
        check("ws_wr_cyc", 64'(c), 64'd5);
        xfer(1, 0, 8'h10, 32'h0, r, e, c, l);
        check("ws_rd_low", 64'(l), 64'd3);
        check("ws_rd_cyc", 64'(c), 64'd5);
        check("ws_rd_data", {32'b0, r}, 64'hCAFEF00D);

        xfer(0, 1, 8'hC7, 32'h0BADF00D, r, e, c, l);
        check("oor_c7_err", {63'b0, e}, 64'h0);
        xfer(0, 1, 8'hC8, 32'h12345678, r, e, c, l);
        check("oor_wr_err", {63'b0, e}, 64'h1);
        xfer(0, 0, 8'hC7, 32'h0, r, e, c, l);
        check("oor_c7_pre", {32'b0, r}, 64'h0BADF00D);
        xfer(0, 0, 8'hC8, 32'h0, r, e, c, l);
        check("oor_rd_err", {63'b0, e}, 64'h1);
        check("oor_rd_data", {32'b0, r}, 64'h0);
        xfer(0, 0, 8'hC7, 32'h0, r, e, c, l);
        check("oor_c7_keep", {32'b0, r}, 64'h0BADF00D);
        check("oor_c7_err2", {63'b0, e}, 64'h0);

`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'hF;
        xfer(0, 1, 8'h20, 32'hFFFFFFFF, r, e, c, l);
        pstrb = 4'b0101;
        xfer(0, 1, 8'h20, 32'h00000000, r, e, c, l);
        pstrb = 4'h0;
        xfer(0, 1, 8'h20, 32'h12345678, r, e, c, l);
        check("strb0_err", {63'b0, e}, 64'h0);
        pstrb = 4'hF;
        xfer(0, 0, 8'h20, 32'h0, r, e, c, l);
        check("strb_rd", {32'b0, r}, 64'hFF00FF00);
`endif

        xfer(1, 1, 8'h30, 32'h13579BDF, r, e, c, l);
        dsel = 1; psel = 1; penable = 0; pwrite = 1;
        paddr = 8'h30; pwdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0;
        @(posedge clk); #1;
        check("abort_pready", {63'b0, b1.pready}, 64'h0);
        xfer(1, 0, 8'h30, 32'h0, r, e, c, l);
        check("abort_mem", {32'b0, r}, 64'h13579BDF);

        t0 = $time;
        for (int i = 0; i < 4; i++)
            xfer(0, 1, 8'(i), 32'hB0B0_0000 + 32'(i), r, e, c, l);
        check("b2b_cycles", 64'(($time - t0) / 10), 64'd8);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 8'(i), 32'h0, r, e, c, l);
            check($sformatf("b2b_rd%0d", i), {32'b0, r},
                  {32'b0, 32'hB0B0_0000 + 32'(i)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
